// File: rtl/pmem_responder.sv
// Line-granular memory responder for the cache's physical-memory bus.
// Accepts one request at a time and answers with a single-cycle resp after LATENCY cycles.
module pmem_responder #(
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_action_stb,
    input  logic                  mem_action_cyc,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [LINE_WIDTH-1:0] mem_wdata,
    output logic [LINE_WIDTH-1:0] mem_rdata,
    output logic                  mem_resp,
    output logic                  mem_retry
);

    localparam int unsigned OFF  = $clog2(LINE_WIDTH / 8);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned CNTW = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP,
        S_DONE
    } state_e;

    state_e                state_q;
    logic [CNTW-1:0]       cnt_q;
    logic [IDXW-1:0]       idx_q;
    logic                  write_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] rdata_q;
    logic                  resp_q;
    logic [LINE_WIDTH-1:0] mem_q [DEPTH];

    logic                  req_c;
    logic                  unused_addr;

    assign req_c       = mem_action_stb & mem_action_cyc;
    // Offset bits and bits above the index alias onto the same line.
    assign unused_addr = ^mem_address;

    // Control FSM; request fields are frozen at accept until resp.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_c) begin
                        idx_q   <= mem_address[OFF +: IDXW];
                        write_q <= mem_write;
                        wdata_q <= mem_wdata;
                        cnt_q   <= CNTW'(LATENCY - 1);
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!req_c) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= S_RESP;
                        resp_q  <= 1'b1;
                        if (!write_q) begin
                            rdata_q <= mem_q[idx_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                S_RESP:  state_q <= S_DONE;
                // Dead cycle so a strobe still held after resp is not re-accepted.
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Line store is not reset; a write commits at the edge ending the resp cycle.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_RESP && write_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_resp  = resp_q;
    assign mem_retry = req_c & ~resp_q & ~rst;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_pmem_responder;

    logic         clk;
    logic         rst4;
    logic         rst1;
    logic         stb;
    logic         cyc;
    logic         we;
    logic [15:0]  addr;
    logic [127:0] wdata;

    logic [127:0] rdata4;
    logic         resp4;
    logic         retry4;
    logic [127:0] rdata1;
    logic         resp1;
    logic         retry1;

    logic         sel;
    logic [127:0] rdata_o;
    logic         resp_o;
    logic         retry_o;

    int           errors = 0;
    int           checks = 0;
    int           lat    = 4;
    logic [127:0] last_rd;

    localparam logic [127:0] D0 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] LA = 128'hA5A5A5A5_11112222_33334444_5A5A5A5A;
    localparam logic [127:0] LB = 128'hB0B0B0B0_DEADBEEF_CAFEF00D_0B0B0B0B;
    localparam logic [127:0] LC = 128'hCCCCCCCC_00000000_FFFFFFFF_12345678;
    localparam logic [127:0] LD = 128'hD00DD00D_87654321_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] LE = 128'hEEEE0001_EEEE0002_EEEE0003_EEEE0004;
    localparam logic [127:0] LG = 128'h99990000_88881111_77772222_66663333;
    localparam logic [127:0] LH = 128'h1357_9BDF_2468_ACE0_1357_9BDF_2468_ACE0;
    localparam logic [127:0] LJ = 128'hFEDCBA98_76543210_FEDCBA98_76543210;
    localparam logic [127:0] LK = 128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF;

    pmem_responder #(.LINE_WIDTH(128), .ADDR_WIDTH(16), .DEPTH(256), .LATENCY(4)) dut4 (
        .clk            (clk),
        .rst            (rst4),
        .mem_action_stb (stb),
        .mem_action_cyc (cyc),
        .mem_write      (we),
        .mem_address    (addr),
        .mem_wdata      (wdata),
        .mem_rdata      (rdata4),
        .mem_resp       (resp4),
        .mem_retry      (retry4)
    );

    pmem_responder #(.LINE_WIDTH(128), .ADDR_WIDTH(16), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk            (clk),
        .rst            (rst1),
        .mem_action_stb (stb),
        .mem_action_cyc (cyc),
        .mem_write      (we),
        .mem_address    (addr),
        .mem_wdata      (wdata),
        .mem_rdata      (rdata1),
        .mem_resp       (resp1),
        .mem_retry      (retry1)
    );

    assign rdata_o = sel ? rdata1 : rdata4;
    assign resp_o  = sel ? resp1  : resp4;
    assign retry_o = sel ? retry1 : retry4;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One transaction from IDLE; optionally hold the strobe after resp or perturb inputs in BUSY.
    task automatic do_txn(input logic wr, input logic [15:0] a, input logic [127:0] d,
                          input logic [127:0] exp_rd, input int hold, input bit keep,
                          input bit chg);
        stb = 1'b1; cyc = 1'b1; we = wr; addr = a; wdata = d;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == lat + 1) begin
                chk1("resp_pulse", resp_o, 1'b1);
                chk1("retry_at_resp", retry_o, 1'b0);
                if (!wr) last_rd = exp_rd;
                chkw(wr ? "rdata_hold_on_write" : "rdata_read", rdata_o, last_rd);
            end else begin
                chk1("resp_early", resp_o, 1'b0);
                chk1("retry_busy", retry_o, 1'b1);
                if (chg && k == 1) begin
                    addr = a ^ 16'h0010; wdata = ~d; we = ~wr;
                end
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk1("resp_held", resp_o, 1'b0);
            chk1("retry_held", retry_o, 1'b1);
        end
        if (!keep) begin
            stb = 1'b0; cyc = 1'b0; we = 1'b0;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                chk1("resp_after", resp_o, 1'b0);
                chk1("retry_after", retry_o, 1'b0);
            end
        end
    endtask

    // Request dropped on the second BUSY cycle: no resp, rdata untouched.
    task automatic do_abort(input logic wr, input logic [15:0] a, input logic [127:0] d);
        stb = 1'b1; cyc = 1'b1; we = wr; addr = a; wdata = d;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk1("abort_resp_busy", resp_o, 1'b0);
            chk1("abort_retry_busy", retry_o, 1'b1);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        for (int k = 0; k < lat + 3; k++) begin
            @(negedge clk);
            chk1("abort_no_resp", resp_o, 1'b0);
            chk1("abort_retry", retry_o, 1'b0);
            chkw("abort_rdata", rdata_o, last_rd);
        end
    endtask

    // Reset asserted while BUSY, after 'at' BUSY cycles have been seen.
    task automatic do_rst_mid(input logic wr, input logic [15:0] a, input logic [127:0] d,
                              input int at);
        stb = 1'b1; cyc = 1'b1; we = wr; addr = a; wdata = d;
        for (int k = 1; k <= at; k++) begin
            @(negedge clk);
            chk1("rstmid_resp_busy", resp_o, 1'b0);
            chk1("rstmid_retry_busy", retry_o, 1'b1);
        end
        if (sel) rst1 = 1'b1; else rst4 = 1'b1;
        @(negedge clk);
        chk1("rstmid_resp", resp_o, 1'b0);
        chk1("rstmid_retry", retry_o, 1'b0);
        chkw("rstmid_rdata", rdata_o, 128'h0);
        last_rd = '0;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (sel) rst1 = 1'b0; else rst4 = 1'b0;
        for (int k = 0; k < lat + 3; k++) begin
            @(negedge clk);
            chk1("rstmid_no_resp", resp_o, 1'b0);
        end
    endtask

    initial begin
        rst4 = 1'b1; rst1 = 1'b1; sel = 1'b0; lat = 4; last_rd = '0;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);

        // Reset state, with a request present while reset is held.
        stb = 1'b1; cyc = 1'b1;
        @(negedge clk);
        chk1("reset_resp", resp_o, 1'b0);
        chk1("reset_retry", retry_o, 1'b0);
        chkw("reset_rdata", rdata_o, 128'h0);
        stb = 1'b0; cyc = 1'b0; rst4 = 1'b0;
        @(negedge clk);
        chk1("idle_retry", retry_o, 1'b0);

        // Write then read.
        do_txn(1'b1, 16'h0040, D0, '0, 0, 1'b0, 1'b0);
        do_txn(1'b0, 16'h0040, '0, D0, 0, 1'b0, 1'b0);

        // Strobe held through DONE and IDLE, then a new read follows directly.
        do_txn(1'b0, 16'h0040, '0, D0, 2, 1'b1, 1'b0);
        do_txn(1'b0, 16'h0040, '0, D0, 0, 1'b0, 1'b0);

        // Aliasing through offset and upper address bits.
        do_txn(1'b1, 16'h0050, LA, '0, 0, 1'b0, 1'b0);
        do_txn(1'b0, 16'h005F, '0, LA, 0, 1'b0, 1'b0);
        do_txn(1'b0, 16'h1050, '0, LA, 0, 1'b0, 1'b0);

        // Aborted read and aborted write leave the line intact.
        do_txn(1'b1, 16'h0060, LB, '0, 0, 1'b0, 1'b0);
        do_abort(1'b0, 16'h0060, '0);
        do_abort(1'b1, 16'h0060, LC);
        do_txn(1'b1, 16'h0070, LD, '0, 0, 1'b0, 1'b0);
        do_txn(1'b0, 16'h0060, '0, LB, 0, 1'b0, 1'b0);
        do_txn(1'b0, 16'h0070, '0, LD, 0, 1'b0, 1'b0);

        // Inputs changed during BUSY of a write are ignored.
        do_txn(1'b1, 16'h0090, LG, '0, 0, 1'b0, 1'b0);
        do_txn(1'b1, 16'h0080, LE, '0, 0, 1'b0, 1'b1);
        do_txn(1'b0, 16'h0080, '0, LE, 0, 1'b0, 1'b0);
        do_txn(1'b0, 16'h0090, '0, LG, 0, 1'b0, 1'b0);

        // Reset during a write discards it.
        do_rst_mid(1'b1, 16'h0040, LH, 2);
        do_txn(1'b0, 16'h0040, '0, D0, 0, 1'b0, 1'b0);

        // Same flow on the LATENCY=1 instance.
        rst4 = 1'b1; sel = 1'b1; lat = 1; last_rd = '0; rst1 = 1'b0;
        @(negedge clk);
        chkw("lat1_reset_rdata", rdata_o, 128'h0);
        do_txn(1'b1, 16'h0040, LJ, '0, 0, 1'b0, 1'b0);
        do_txn(1'b0, 16'h0040, '0, LJ, 0, 1'b0, 1'b0);
        do_rst_mid(1'b1, 16'h0040, LK, 1);
        do_txn(1'b0, 16'h0040, '0, LJ, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
